serial_subtractor: RTL and testbench
====================================

# serial_subtractor

- Multi-cycle, parametrised subtractor computing `diff = a - b - bor_in` over `WIDTH` bits.
- Processes `DIGIT` bits per clock, LSB digit first, carrying the borrow between cycles in a register.
- Trades latency for area relative to a flat ripple subtractor.
- Sits in the arithmetic datapath beside the single-bit combinational subtractor cells and is driven by a start/done handshake from the controlling FSM.

## Interface

Parameters:
- `WIDTH`, 16, operand and result width in bits; must be a multiple of `DIGIT`.
- `DIGIT`, 4, bits processed per cycle; 1 ≤ `DIGIT` ≤ `WIDTH`.

Ports:
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  `WIDTH`  minuend; captured on accepted start.
- `b`  in  `WIDTH`  subtrahend; captured on accepted start.
- `bor_in`  in  1  borrow-in; captured on accepted start.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; results valid.
- `diff`  out  `WIDTH`  difference.
- `bor_out`  out  1  final borrow-out, i.e. unsigned underflow.
- `ovf`  out  1  signed overflow; only meaningful with the macro.

## Operation

- Let N = `WIDTH`/`DIGIT`.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 captures `a`, `b` and `bor_in` into operand registers.
  - Clears the digit counter and moves to RUN.
  - `start`=0 stays in IDLE.
- RUN, once per cycle:
  - Low `DIGIT` bits of the operand registers go through a `DIGIT`-wide borrow-ripple slice with the borrow register as input.
  - The slice result shifts into the top of the `diff` register, and the operand registers shift right by `DIGIT`.
  - The borrow register takes the slice borrow-out, and the counter increments.
  - After the Nth digit, go to DONE.
- DONE:
  - Lasts exactly one cycle, with `done`=1.
  - `diff` holds the full result, and `bor_out` equals the borrow register.
  - Then returns to IDLE.
- Per-bit arithmetic:
  - d = x ^ y ^ bi
  - bo = (~x & y) | (bi & ~(x ^ y))
- Ignored `start`:
  - `start` in RUN or DONE is ignored, with no queuing.
  - A caller must wait for IDLE (`busy`=0).
- Output holding:
  - `diff`, `bor_out` and `ovf` hold their last result through IDLE until the next accepted start.
  - In RUN, `diff` is partial and undefined to consumers.
- Degenerate width: with `DIGIT`=`WIDTH` (N=1), RUN lasts one cycle.
- Reset (any state, including mid-RUN):
  - FSM returns to IDLE; `busy`=0, `done`=0, `diff`=0, `bor_out`=0, `ovf`=0.
  - Counter and operand registers are cleared, and the partial result is discarded.

## Timing

- Start accepted at rising edge k; RUN occupies cycles k+1 … k+N.
- `done`=1 during cycle k+N+1; `busy`=0 from k+N+2.
- Total latency start→done is N+1 cycles, and back-to-back throughput is one operation per N+2 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.
- Input operands need only be stable at the accepting edge.

## Configuration

- `SERIAL_SUBTRACTOR_OVF_EN` defined:
  - `ovf` is registered at the transition to DONE as `(a_msb ^ b_msb) & (diff_msb ^ a_msb)`, using captured operand MSBs.
  - Valid with `done` and held like `diff`.
- Undefined: `ovf` is tied to 0, and the MSB capture logic is removed.

## Structure

- Package `serial_subtractor_pkg`:
  - State enum `sub_state_t` (IDLE, RUN, DONE).
  - Helper function for counter width, clog2 of N+1.
- One sub-module, `digit_subtractor`:
  - Combinational `DIGIT`-wide borrow-ripple slice.
  - Ports: `x`, `y`, `bi`, `d`, `bo`.
  - Verifiable standalone against `x - y - bi`.

## Test plan

All cases use `WIDTH`=16, `DIGIT`=4.

- `a`=0x0005, `b`=0x0003, `bor_in`=0, start at edge 0 → `done` at cycle 5, `diff`=0x0002, `bor_out`=0.
- `a`=0x0000, `b`=0x0001, `bor_in`=0 → `diff`=0xFFFF, `bor_out`=1.
- `a`=0x1234, `b`=0x1234, `bor_in`=1 → `diff`=0xFFFF, `bor_out`=1; borrow propagates through all 4 digits.
- Macro defined: `a`=0x8000, `b`=0x0001 → `diff`=0x7FFF, `ovf`=1, `bor_out`=0. Macro undefined: same operands → `ovf`=0.
- `start` pulsed again during RUN with different operands → ignored; first result is correct, `done` pulses exactly once.
- `rst_n` low at cycle 2 of RUN → all outputs 0 and state IDLE immediately. New start after release → correct result in N+1 cycles.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
// Optional signed-overflow flag: SERIAL_SUBTRACTOR_OVF_EN.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

    // Counter width able to hold 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-wide borrow-ripple slice.
// Computes {bo, d} = x - y - bi.
module digit_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    // Ripple the borrow from the LSB upward through the slice.
    always_comb begin
        logic [DIGIT:0] c;
        c    = '0;
        d    = '0;
        c[0] = bi;
        for (int i = 0; i < DIGIT; i++) begin
            d[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (~x[i] & y[i]) | (c[i] & ~(x[i] ^ y[i]));
        end
        bo = c[DIGIT];
    end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bor_in, DIGIT bits per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to register the signed-overflow flag.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bor_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bor_out,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    sub_state_t       state;
    logic [WIDTH-1:0] ar;
    logic [WIDTH-1:0] br;
    logic             bor_r;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dsl;
    logic             bsl;
    logic [WIDTH-1:0] diff_nxt;

    digit_subtractor #(
        .DIGIT (DIGIT)
    ) u_slice (
        .x  (ar[DIGIT-1:0]),
        .y  (br[DIGIT-1:0]),
        .bi (bor_r),
        .d  (dsl),
        .bo (bsl)
    );

    // New digit enters at the top so the LSB digit ends at the bottom.
    generate
        if (DIGIT == WIDTH) begin : g_one
            assign diff_nxt = dsl;
        end else begin : g_many
            assign diff_nxt = {dsl, diff[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ar      <= '0;
            br      <= '0;
            bor_r   <= 1'b0;
            cnt     <= '0;
            diff    <= '0;
            bor_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ar    <= a;
                        br    <= b;
                        bor_r <= bor_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    ar    <= ar >> DIGIT;
                    br    <= br >> DIGIT;
                    bor_r <= bsl;
                    diff  <= diff_nxt;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        bor_out <= bsl;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb;
    logic b_msb;

    // Capture operand signs on start; judge overflow on the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == RUN && cnt == LAST) begin
            ovf <= (a_msb ^ b_msb) & (diff_nxt[WIDTH-1] ^ a_msb);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Vector table plus scoreboard bench for serial_subtractor.
// Expected ovf is masked to 0 unless SERIAL_SUBTRACTOR_OVF_EN.
module tb_serial_subtractor;

    localparam int W = 16;
    localparam int D = 4;
    localparam int N = W / D;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
    } vec_t;

    typedef struct {
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bor_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bor_out;
    logic         ovf;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    exp_t sbq[$];
    vec_t tbl[6];

    serial_subtractor #(
        .WIDTH (W),
        .DIGIT (D)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .bor_in  (bor_in),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bor_out (bor_out),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic ovf_mask(input logic o);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        return o;
`else
        return 1'b0 & o;
`endif
    endfunction

    // Scoreboard checker: every done pulse must match the oldest request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            if (sbq.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("diff", 32'(diff), 32'(e.ed));
                chk("bor_out", 32'(bor_out), 32'(e.eb));
                chk("ovf", 32'(ovf), 32'(e.eo));
                chk("latency", 32'(cyc - e.acc), 32'(N + 1));
                chk("busy_in_done", 32'(busy), 32'd1);
            end
        end
    end

    task automatic issue(input vec_t v);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
        a      = v.a;
        b      = v.b;
        bor_in = v.bin;
        start  = 1'b1;
        @(posedge clk);
        e.ed  = v.ed;
        e.eb  = v.eb;
        e.eo  = ovf_mask(v.eo);
        e.acc = cyc;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            chk("done_timeout", 32'd1, 32'd0);
            sbq.delete();
        end
    endtask

    initial begin
        vec_t         v;
        logic [W:0]   m;
        logic [W-1:0] x;
        int           dc;

        tbl[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[2] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        tbl[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bor", 32'(bor_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            issue(tbl[i]);
            wait_done();
            repeat (2) @(negedge clk);
            chk("hold_diff", 32'(diff), 32'(tbl[i].ed));
            chk("hold_bor", 32'(bor_out), 32'(tbl[i].eb));
            chk("idle_busy", 32'(busy), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            v.a   = W'($urandom);
            v.b   = W'($urandom);
            v.bin = 1'($urandom);
            m     = {1'b0, v.a} - {1'b0, v.b} - (W+1)'(v.bin);
            v.ed  = m[W-1:0];
            v.eb  = m[W];
            x     = (v.a ^ v.b) & (v.ed ^ v.a);
            v.eo  = x[W-1];
            issue(v);
            wait_done();
        end

        dc = done_cnt;
        issue(tbl[0]);
        @(negedge clk);
        a      = 16'hFFFF;
        b      = 16'h0000;
        bor_in = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);
        chk("single_done", 32'(done_cnt - dc), 32'd1);
        chk("ign_idle", 32'(busy), 32'd0);

        issue(tbl[2]);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_bor", 32'(bor_out), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        sbq.delete();
        dc = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt - dc), 32'd0);
        chk("rst_idle", 32'(busy), 32'd0);
        issue(tbl[1]);
        wait_done();
        issue(tbl[3]);
        wait_done();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
